// File: rtl/shared_data_axi_writer_if.sv
// AXI4-lite bus bundle between the shared-data writer (initiator) and the
// shared data memory slave port.
//   Write address : awaddr, awprot, awvalid (m->s), awready (s->m)
//   Write data    : wdata, wstrb, wvalid (m->s), wready (s->m)
//   Write response: bresp, bvalid (s->m), bready (m->s)
//   Read channels : present for completeness; the writer never reads
// Modports: m = initiator side, s = slave side.
interface shared_data_axi_writer_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport m (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport s (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/shared_data_axi_writer.sv
// Packs the EVR distributed-data-buffer byte stream into little-endian
// 32-bit words, queues them in a small FIFO and writes each one to the
// shared data memory over AXI4-lite (one transaction outstanding).
// Ports:
//   clk, aresetn          clock, asynchronous active-low reset
//   db_valid/db_data      byte stream (cannot be back-pressured)
//   db_start/db_last      first/last byte of a buffer, qualified by db_valid
//   m_axi                 AXI4-lite initiator (write channels only)
//   busy                  FIFO non-empty or a transaction in flight
//   done                  one-cycle pulse when the last word's B arrives
//   overflow, resp_err    sticky status, cleared by db_start
//   words_written         B responses since the last db_start (saturating)
module shared_data_axi_writer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          MAX_BYTES  = 2048,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      db_valid,
    input  logic [7:0]                db_data,
    input  logic                      db_start,
    input  logic                      db_last,
    shared_data_axi_writer_if.m       m_axi,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      resp_err,
    output logic [15:0]               words_written
);
    localparam int OFFW = $clog2(MAX_BYTES);
    localparam int PTRW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    logic [OFFW-1:0] byteOff_q;
    logic [31:0]     wordData_q;
    logic [3:0]      wordStrb_q;
    logic            push_q;
    entry_t          pushEntry_q;

    entry_t          fifoMem_q [FIFO_DEPTH];
    logic [PTRW-1:0] wrPtr_q;
    logic [PTRW-1:0] rdPtr_q;
    logic [PTRW:0]   count_q;

    state_t          state_q;
    logic            awvalid_q;
    logic            wvalid_q;
    logic            bready_q;
    logic            done_q;
    logic            overflow_q;
    logic            respErr_q;
    logic [15:0]     wordsWritten_q;

    logic            startNow;
    logic [OFFW-1:0] effOff;
    logic [1:0]      lane;
    logic [31:0]     curData;
    logic [3:0]      curStrb;
    logic            pushNow;
    logic            pop;
    logic            fifoFull;
    logic            pushAccept;
    entry_t          head;
    logic            unusedOk;

    // A start byte restarts the offset and throws away any partial word.
    always_comb begin
        startNow = db_valid && db_start;
        effOff   = startNow ? '0 : byteOff_q;
        lane     = effOff[1:0];
        curData  = startNow ? '0 : wordData_q;
        curStrb  = startNow ? '0 : wordStrb_q;
        curData[{lane, 3'b000} +: 8] = db_data;
        curStrb[lane] = 1'b1;
        pushNow  = db_valid && ((lane == 2'd3) || db_last);
    end

    // The completed word is staged one cycle before it enters the FIFO.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            byteOff_q   <= '0;
            wordData_q  <= '0;
            wordStrb_q  <= '0;
            push_q      <= 1'b0;
            pushEntry_q <= '0;
        end else begin
            push_q <= pushNow;
            if (db_valid) begin
                byteOff_q <= effOff + OFFW'(1);
                if (pushNow) begin
                    pushEntry_q.addr <= BASE_ADDR + 32'(effOff & ~OFFW'(3));
                    pushEntry_q.data <= curData;
                    pushEntry_q.strb <= curStrb;
                    pushEntry_q.last <= db_last;
                    wordData_q       <= '0;
                    wordStrb_q       <= '0;
                end else begin
                    wordData_q <= curData;
                    wordStrb_q <= curStrb;
                end
            end
        end
    end

    // The head is popped only by the B handshake; a pop in the same cycle
    // frees room for a push into a full FIFO.
    assign pop        = (state_q == RESP) && m_axi.bvalid;
    assign fifoFull   = (count_q == (PTRW+1)'(FIFO_DEPTH));
    assign pushAccept = push_q && (!fifoFull || pop);
    assign head       = fifoMem_q[rdPtr_q];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifoMem_q[i] <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushAccept) begin
                fifoMem_q[wrPtr_q] <= pushEntry_q;
                wrPtr_q            <= wrPtr_q + PTRW'(1);
            end
            if (pop) rdPtr_q <= rdPtr_q + PTRW'(1);
            case ({pushAccept, pop})
                2'b10:   count_q <= count_q + (PTRW+1)'(1);
                2'b01:   count_q <= count_q - (PTRW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Write FSM: AW and W are raised together and each drops on its own
    // handshake; the response phase starts once both have completed.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q   <= ADDR;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                    end
                end
                ADDR: begin
                    if (m_axi.awready) awvalid_q <= 1'b0;
                    if (m_axi.wready) wvalid_q <= 1'b0;
                    if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
                        state_q  <= RESP;
                        bready_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (m_axi.bvalid) begin
                        state_q  <= IDLE;
                        bready_q <= 1'b0;
                        done_q   <= head.last;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Status: db_start clears first, so a B arriving on the same edge
    // already counts toward the new buffer.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_q     <= 1'b0;
            respErr_q      <= 1'b0;
            wordsWritten_q <= '0;
        end else begin
            if (push_q && !pushAccept) overflow_q <= 1'b1;
            else if (startNow) overflow_q <= 1'b0;

            if (pop && (m_axi.bresp != 2'b00)) respErr_q <= 1'b1;
            else if (startNow) respErr_q <= 1'b0;

            if (pop) begin
                if (startNow) wordsWritten_q <= 16'd1;
                else if (wordsWritten_q != 16'hFFFF) wordsWritten_q <= wordsWritten_q + 16'd1;
            end else if (startNow) begin
                wordsWritten_q <= '0;
            end
        end
    end

    assign m_axi.awaddr  = head.addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = head.data;
    assign m_axi.wstrb   = head.strb;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = '0;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = 1'b0;
    assign m_axi.rready  = 1'b0;

    assign unusedOk = ^{m_axi.arready, m_axi.rdata, m_axi.rresp, m_axi.rvalid};

    assign busy          = (count_q != '0) || (state_q != IDLE);
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign resp_err      = respErr_q;
    assign words_written = wordsWritten_q;
endmodule

// File: tb/tb_shared_data_axi_writer.sv
// Scoreboard bench for shared_data_axi_writer: the stimulus side predicts the
// writes of each buffer from byte positions and pushes them into a queue; a
// negedge monitor, which also plays the AXI slave, pops and compares on
// every B handshake.
`timescale 1ns/1ps
module tb_shared_data_axi_writer;
    localparam logic [31:0] BASE  = 32'h0000_0200;
    localparam int          MAXB  = 16;
    localparam int          DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        dbValid = 1'b0;
    logic [7:0]  dbData = 8'h00;
    logic        dbStart = 1'b0;
    logic        dbLast = 1'b0;
    logic        busy, done, overflow, respErr;
    logic [15:0] wordsWritten;

    shared_data_axi_writer_if axi();

    shared_data_axi_writer #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .aresetn(aresetn),
        .db_valid(dbValid), .db_data(dbData), .db_start(dbStart), .db_last(dbLast),
        .m_axi(axi),
        .busy(busy), .done(done), .overflow(overflow), .resp_err(respErr),
        .words_written(wordsWritten)
    );

    always #5 clk = ~clk;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Slave knobs and model state shared between stimulus and monitor.
    int   awStall = 0;
    bit   awBlock = 0;
    bit   bHold = 0;
    int   errAt = -1;
    bit   randErr = 0;
    bit   randWStall = 0;
    int   bInBuf = 0;
    int   wwModel = 0;
    bit   errModel = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte k sits in word k/4, lane k%4; the word address
    // is the word's first byte offset modulo the buffer size.
    task automatic modelBuffer(input logic [7:0] bytes[$], input bit markLast, input int keep);
        int n = bytes.size();
        int nWords = markLast ? (n + 3) / 4 : n / 4;
        for (int w = 0; w < nWords; w++) begin
            exp_t e;
            e.data = '0;
            e.strb = '0;
            e.addr = BASE + 32'((w * 4) % MAXB);
            for (int j = 0; j < 4; j++) begin
                if (w * 4 + j < n) begin
                    e.data[8*j +: 8] = bytes[w*4 + j];
                    e.strb[j] = 1'b1;
                end
            end
            e.last = markLast && (w == nWords - 1);
            if (w < keep) expQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] bytes[$], input int gapMax, input bit markLast, input int keep);
        modelBuffer(bytes, markLast, keep);
        for (int k = 0; k < bytes.size(); k++) begin
            int gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
            @(posedge clk); #1;
            dbValid = 1'b1;
            dbData  = bytes[k];
            dbStart = (k == 0);
            dbLast  = markLast && (k == bytes.size() - 1);
            if (k == 0) begin
                wwModel  = 0;
                errModel = 0;
                bInBuf   = 0;
            end
            if (gap > 0) begin
                @(posedge clk); #1;
                dbValid = 1'b0; dbStart = 1'b0; dbLast = 1'b0;
                repeat (gap - 1) @(posedge clk);
            end
        end
        @(posedge clk); #1;
        dbValid = 1'b0; dbStart = 1'b0; dbLast = 1'b0;
    endtask

    task automatic buildSeq(input int first, input int n, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'(first + i));
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while ((busy || expQ.size() != 0) && n < maxCycles);
        if (busy || expQ.size() != 0) checkOutput("idleTimeout", 32'(expQ.size()), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".done"}, done, 0);
        checkOutput({tag, ".overflow"}, overflow, 0);
        checkOutput({tag, ".resp_err"}, respErr, 0);
        checkOutput({tag, ".words_written"}, wordsWritten, 0);
        checkOutput({tag, ".awvalid"}, axi.awvalid, 0);
        checkOutput({tag, ".wvalid"}, axi.wvalid, 0);
        checkOutput({tag, ".bready"}, axi.bready, 0);
    endtask

    // Monitor + slave. Handshakes seen at one negedge complete at the next
    // posedge and are scored at the negedge after that.
    bit          gotAw, gotW, pAwHs, pWHs, pBHs, pAwPend, pWPend, lastWLow;
    logic [31:0] capAddr, capData, pAwAddr, pWData;
    logic [3:0]  capStrb, pWStrb;
    exp_t        monExp;

    initial begin
        axi.arready = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rvalid = 1'b0;
    end

    initial begin : monitor
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        gotAw = 0; gotW = 0; pAwHs = 0; pWHs = 0; pBHs = 0; pAwPend = 0; pWPend = 0; lastWLow = 0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
                gotAw = 0; gotW = 0; pAwHs = 0; pWHs = 0; pBHs = 0; pAwPend = 0; pWPend = 0;
                continue;
            end
            if (pAwHs) begin
                checkOutput("awPerWrite", gotAw ? 2 : 1, 1);
                gotAw = 1; capAddr = pAwAddr;
            end
            if (pWHs) begin
                checkOutput("wPerWrite", gotW ? 2 : 1, 1);
                gotW = 1; capData = pWData; capStrb = pWStrb;
            end
            if (pBHs) begin
                checkOutput("bAfterAwW", {gotAw, gotW}, 2'b11);
                if (axi.bresp != 2'b00) errModel = 1;
                wwModel = (wwModel == 65535) ? 65535 : wwModel + 1;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedB", 1, 0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("awaddr", capAddr, monExp.addr);
                    checkOutput("wdata", capData, monExp.data);
                    checkOutput("wstrb", 32'(capStrb), 32'(monExp.strb));
                    checkOutput("donePulse", done, 32'(monExp.last));
                end
                checkOutput("wordsWrittenAtB", wordsWritten, 32'(wwModel));
                checkOutput("respErrAtB", respErr, 32'(errModel));
                gotAw = 0; gotW = 0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
                bInBuf++;
            end else if (done) begin
                checkOutput("spuriousDone", done, 0);
            end
            if (pAwPend) begin
                checkOutput("awvalidHold", axi.awvalid, 1);
                checkOutput("awaddrHold", axi.awaddr, pAwAddr);
            end
            if (pWPend) begin
                checkOutput("wvalidHold", axi.wvalid, 1);
                checkOutput("wdataHold", axi.wdata, pWData);
            end
            if (axi.awvalid && !gotAw && (awBlock || awStall > 0)) begin
                axi.awready = 1'b0;
                if (!awBlock) awStall--;
            end else begin
                axi.awready = 1'b1;
            end
            axi.wready = !(randWStall && !lastWLow && ($urandom_range(3, 0) == 0));
            lastWLow = !axi.wready;
            if (gotAw && gotW && !axi.bvalid && !bHold) begin
                axi.bvalid = 1'b1;
                axi.bresp = ((bInBuf == errAt) || (randErr && $urandom_range(5, 0) == 0)) ? 2'b10 : 2'b00;
            end
            pAwHs   = axi.awvalid && axi.awready;
            pWHs    = axi.wvalid && axi.wready;
            pBHs    = axi.bvalid && axi.bready;
            pAwPend = axi.awvalid && !axi.awready;
            pWPend  = axi.wvalid && !axi.wready;
            pAwAddr = axi.awaddr;
            pWData  = axi.wdata;
            pWStrb  = axi.wstrb;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d vectors", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] b[$];
        int n;
        bit gotReady;

        #12;
        checkAllZero("reset");
        @(posedge clk); #1;
        aresetn = 1'b1;

        // Eight bytes: two full words and a done pulse.
        buildSeq(8'h00, 8, b);
        applyStimulus(b, 0, 1, 99);
        waitIdle(200);
        checkOutput("t1.words_written", wordsWritten, 2);
        checkOutput("t1.overflow", overflow, 0);

        // Five bytes: second word carries a single byte in lane 0.
        buildSeq(8'h10, 5, b);
        applyStimulus(b, 0, 1, 99);
        waitIdle(200);
        checkOutput("t2.words_written", wordsWritten, 2);

        // Address channel stalled three cycles while data goes straight through.
        awStall = 3;
        buildSeq(8'h20, 4, b);
        applyStimulus(b, 0, 1, 99);
        waitIdle(200);
        checkOutput("t3.words_written", wordsWritten, 1);

        // An unterminated partial word is discarded by the next start.
        buildSeq(8'h30, 3, b);
        applyStimulus(b, 0, 0, 99);
        buildSeq(8'h40, 4, b);
        applyStimulus(b, 0, 1, 99);
        waitIdle(200);
        checkOutput("discard.words_written", wordsWritten, 1);

        // Blocked slave: only the first DEPTH words survive.
        awBlock = 1;
        buildSeq(8'h50, 24, b);
        applyStimulus(b, 0, 1, DEPTH);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("t4.overflow", overflow, 1);
        checkOutput("t4.busy", busy, 1);
        awBlock = 0;
        waitIdle(300);
        checkOutput("t4.words_written", wordsWritten, DEPTH);
        checkOutput("t4.overflowSticky", overflow, 1);

        // Slave error on the second of three writes.
        errAt = 1;
        buildSeq(8'h80, 12, b);
        applyStimulus(b, 0, 1, 99);
        waitIdle(300);
        errAt = -1;
        checkOutput("t5.resp_err", respErr, 1);
        checkOutput("t5.words_written", wordsWritten, 3);
        checkOutput("t5.overflowCleared", overflow, 0);
        buildSeq(8'h90, 1, b);
        applyStimulus(b, 0, 1, 99);
        waitIdle(200);
        checkOutput("t5.respErrCleared", respErr, 0);
        checkOutput("t5.words_written1", wordsWritten, 1);

        // Twenty bytes into a 16-byte buffer: the fifth write wraps to offset 0.
        buildSeq(8'hA0, 20, b);
        applyStimulus(b, 0, 1, 99);
        waitIdle(300);
        checkOutput("t6.words_written", wordsWritten, 5);

        // Reset while waiting for a response: everything clears at once.
        bHold = 1;
        buildSeq(8'hC0, 8, b);
        applyStimulus(b, 0, 1, 99);
        gotReady = 0;
        for (int i = 0; i < 50 && !gotReady; i++) begin
            @(posedge clk); #2;
            gotReady = axi.bready;
        end
        checkOutput("rst.reachedResp", gotReady, 1);
        aresetn = 1'b0;
        #1;
        checkAllZero("midReset");
        expQ.delete();
        wwModel = 0; errModel = 0; bHold = 0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            checkOutput("rst.fifoEmpty", busy, 0);
        end
        buildSeq(8'hD0, 4, b);
        applyStimulus(b, 0, 1, 99);
        waitIdle(200);
        checkOutput("rst.words_written", wordsWritten, 1);

        // Randomised buffers with idle gaps, W stalls and error responses.
        randWStall = 1;
        randErr = 1;
        for (int t = 0; t < 10; t++) begin
            n = int'($urandom_range(20, 1));
            b = {};
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            applyStimulus(b, 2, 1, 99);
            waitIdle(400);
            checkOutput("rand.words_written", wordsWritten, 32'((n + 3) / 4));
            checkOutput("rand.resp_err", respErr, 32'(errModel));
            checkOutput("rand.overflow", overflow, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
